// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg
// Shared definitions for the ECC scrub controller: the scrub sequencer state
// encoding, payload width constants and small helpers used by the top and
// the scrub queue.
//
// The scrub entry record {ch, addr, data} depends on the address-width
// parameter of the controller. It is therefore declared inside the top
// module and handed to the queue as a type parameter. The constants below
// size its fields.
package ecc_scrub_pkg;

    localparam int DATA_W = 32;   // corrected data word carried by an entry
    localparam int CH_W   = 1;    // decoder channel index width
    localparam int N_CH   = 2;    // number of decoder channels

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } scrub_state_t;

    // Number of set bits in a two-channel event vector (0..2).
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/ecc_scrub_fifo.sv
// ecc_scrub_fifo
// Synchronous scrub queue with two ordered push ports and one pop port.
// When both pushes are asserted, push0 is written ahead of push1. When only
// push1 is asserted, it takes the next free slot. The caller decides which
// pushes fit. A pop on an empty queue is ignored.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset (empties queue)
//   push0_i/push0_data_i  first push of the cycle
//   push1_i/push1_data_i  second push of the cycle
//   pop_i                 remove head entry
//   head_o                current head entry (valid when !empty_o)
//   empty_o, count_o      occupancy status
module ecc_scrub_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push0_i,
    input  entry_t           push0_data_i,
    input  logic             push1_i,
    input  entry_t           push1_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr1;
    logic             pop_ok;

    assign pop_ok  = pop_i && !empty_o;
    assign wr_ptr1 = wr_ptr + PTR_W'(push0_i);
    assign head_o  = mem[rd_ptr];
    assign empty_o = (count_o == '0);

    always_ff @(posedge clk_i) begin
        if (push0_i) begin
            mem[wr_ptr] <= push0_data_i;
        end
        if (push1_i) begin
            mem[wr_ptr1] <= push1_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(push0_i) + PTR_W'(push1_i);
            rd_ptr  <= rd_ptr + PTR_W'(pop_ok);
            count_o <= count_o + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
// Watches two ECC decoder channels. It counts corrected (SEC) and
// uncorrectable (DED) events, captures the first DED location, and queues
// corrected words for write-back to the SRAM through a req/ack handshake.
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   cfg_scrub_enable_i                 allow new write-back entries
//   rd_valid_i[1:0]                    per-channel read valid
//   rd_addr0_i, rd_addr1_i             per-channel word address
//   single_error_flag_i[1:0]           per-channel SEC flag
//   double_error_flag_i[1:0]           per-channel DED flag
//   corr_data0_i, corr_data1_i         per-channel corrected data
//   err_clr_i                          clear counters and sticky status
//   scrub_req_o, scrub_ack_i           write-back handshake
//   scrub_ch_o/addr_o/data_o           write-back target and payload
//   sec_cnt_o, ded_cnt_o               saturating event counters
//   ded_valid_o, ded_ch_o, ded_addr_o  first-DED capture
//   scrub_drop_o                       sticky: an entry did not fit the queue
//
// Scrub sequencer states
//   state   | meaning
//   IDLE    | queue empty or not yet examined, no request
//   REQ     | scrub_req_o high, head entry presented until acked
//   GAP     | one dead cycle after an ack before the next request
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_scrub_enable_i,
    input  logic [1:0]        rd_valid_i,
    input  logic [ADDR_W-1:0] rd_addr0_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [1:0]        single_error_flag_i,
    input  logic [1:0]        double_error_flag_i,
    input  logic [31:0]       corr_data0_i,
    input  logic [31:0]       corr_data1_i,
    input  logic              err_clr_i,
    output logic              scrub_req_o,
    input  logic              scrub_ack_i,
    output logic              scrub_ch_o,
    output logic [ADDR_W-1:0] scrub_addr_o,
    output logic [31:0]       scrub_data_o,
    output logic [CNT_W-1:0]  sec_cnt_o,
    output logic [CNT_W-1:0]  ded_cnt_o,
    output logic              ded_valid_o,
    output logic              ded_ch_o,
    output logic [ADDR_W-1:0] ded_addr_o,
    output logic              scrub_drop_o
);

    localparam int QCNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    scrub_state_t      state;
    logic [1:0]        sec_ev;
    logic [1:0]        ded_ev;
    logic              want0, want1;
    logic              acc0, acc1;
    logic              drop_ev;
    logic              q_pop;
    logic              q_empty;
    logic [QCNT_W-1:0] q_count;
    logic [QCNT_W-1:0] q_space;
    entry_t            q_head;
    entry_t            e0, e1;

    // A double flag overrides the single flag on the same channel.
    assign sec_ev = rd_valid_i & single_error_flag_i & ~double_error_flag_i;
    assign ded_ev = rd_valid_i & double_error_flag_i;

    assign want0 = sec_ev[0] && cfg_scrub_enable_i;
    assign want1 = sec_ev[1] && cfg_scrub_enable_i;

    // Only REQ can pop, so state alone qualifies the ack.
    assign q_pop = (state == ST_REQ) && scrub_ack_i;

    // A slot freed by this cycle's pop is reusable by this cycle's push.
    // Channel 0 is served first, so channel 1 is the one that gets dropped.
    always_comb begin
        q_space = QCNT_W'(DEPTH) - q_count + QCNT_W'(q_pop);
        acc0    = want0 && (q_space != '0);
        acc1    = want1 && (q_space > QCNT_W'(acc0));
        drop_ev = (want0 && !acc0) || (want1 && !acc1);
    end

    always_comb begin
        e0.ch   = 1'b0;
        e0.addr = rd_addr0_i;
        e0.data = corr_data0_i;
        e1.ch   = 1'b1;
        e1.addr = rd_addr1_i;
        e1.data = corr_data1_i;
    end

    ecc_scrub_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t),
        .CNT_W   (QCNT_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push0_i      (acc0),
        .push0_data_i (e0),
        .push1_i      (acc1),
        .push1_data_i (e1),
        .pop_i        (q_pop),
        .head_o       (q_head),
        .empty_o      (q_empty),
        .count_o      (q_count)
    );

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // The payload is loaded only on entry to REQ, so it cannot move while
    // a request is outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            scrub_req_o  <= 1'b0;
            scrub_ch_o   <= 1'b0;
            scrub_addr_o <= '0;
            scrub_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        state        <= ST_REQ;
                        scrub_req_o  <= 1'b1;
                        scrub_ch_o   <= q_head.ch;
                        scrub_addr_o <= q_head.addr;
                        scrub_data_o <= q_head.data;
                    end
                end
                ST_REQ: begin
                    if (scrub_ack_i) begin
                        state       <= ST_GAP;
                        scrub_req_o <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (!q_empty) begin
                        state        <= ST_REQ;
                        scrub_req_o  <= 1'b1;
                        scrub_ch_o   <= q_head.ch;
                        scrub_addr_o <= q_head.addr;
                        scrub_data_o <= q_head.data;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    scrub_req_o <= 1'b0;
                end
            endcase
        end
    end

    // A clear wins over events in the same cycle. The queue keeps running.
    always_ff @(posedge clk_i) begin
        if (rst_i || err_clr_i) begin
            sec_cnt_o    <= '0;
            ded_cnt_o    <= '0;
            ded_valid_o  <= 1'b0;
            ded_ch_o     <= 1'b0;
            ded_addr_o   <= '0;
            scrub_drop_o <= 1'b0;
        end else begin
            sec_cnt_o <= sat_add(sec_cnt_o, popcount2(sec_ev));
            ded_cnt_o <= sat_add(ded_cnt_o, popcount2(ded_ev));
            if (!ded_valid_o && (ded_ev != 2'b00)) begin
                ded_valid_o <= 1'b1;
                ded_ch_o    <= !ded_ev[0];
                ded_addr_o  <= ded_ev[0] ? rd_addr0_i : rd_addr1_i;
            end
            if (drop_ev) begin
                scrub_drop_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
module tb_ecc_scrub_ctrl;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 4;
    localparam int MAXC   = 65535;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              cfg_scrub_enable_i = 1'b0;
    logic [1:0]        rd_valid_i = '0;
    logic [ADDR_W-1:0] rd_addr0_i = '0;
    logic [ADDR_W-1:0] rd_addr1_i = '0;
    logic [1:0]        single_error_flag_i = '0;
    logic [1:0]        double_error_flag_i = '0;
    logic [31:0]       corr_data0_i = '0;
    logic [31:0]       corr_data1_i = '0;
    logic              err_clr_i = 1'b0;
    logic              scrub_req_o;
    logic              scrub_ack_i = 1'b0;
    logic              scrub_ch_o;
    logic [ADDR_W-1:0] scrub_addr_o;
    logic [31:0]       scrub_data_o;
    logic [CNT_W-1:0]  sec_cnt_o;
    logic [CNT_W-1:0]  ded_cnt_o;
    logic              ded_valid_o;
    logic              ded_ch_o;
    logic [ADDR_W-1:0] ded_addr_o;
    logic              scrub_drop_o;

    ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_scrub_enable_i(cfg_scrub_enable_i),
        .rd_valid_i(rd_valid_i), .rd_addr0_i(rd_addr0_i), .rd_addr1_i(rd_addr1_i),
        .single_error_flag_i(single_error_flag_i), .double_error_flag_i(double_error_flag_i),
        .corr_data0_i(corr_data0_i), .corr_data1_i(corr_data1_i), .err_clr_i(err_clr_i),
        .scrub_req_o(scrub_req_o), .scrub_ack_i(scrub_ack_i), .scrub_ch_o(scrub_ch_o),
        .scrub_addr_o(scrub_addr_o), .scrub_data_o(scrub_data_o),
        .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o), .ded_valid_o(ded_valid_o),
        .ded_ch_o(ded_ch_o), .ded_addr_o(ded_addr_o), .scrub_drop_o(scrub_drop_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: event counts, first-DED capture, sticky drop, and the
    // scrub queue as a plain FIFO of {ch, addr, data}.
    int          m_sec, m_ded;
    bit          m_dv, m_dch, m_drop;
    int          m_daddr;
    logic [42:0] mq[$];
    logic [43:0] obs_q[$];   // {valid, entry} seen at each DUT handshake
    logic [43:0] exp_q[$];   // {valid, entry} the model expected there

    task automatic set_idle();
        rd_valid_i = '0; single_error_flag_i = '0; double_error_flag_i = '0;
        rd_addr0_i = '0; rd_addr1_i = '0; corr_data0_i = '0; corr_data1_i = '0;
        err_clr_i = 1'b0; scrub_ack_i = 1'b0;
    endtask

    // One clock: observe the handshake, let the edge happen, advance the model.
    task automatic cycle();
        logic        pre_req, pop;
        logic [42:0] pre_e;
        bit          s0, s1, d0, d1, drop_evt;
        int          space;
        pre_req = scrub_req_o;
        pre_e   = {scrub_ch_o, scrub_addr_o, scrub_data_o};
        pop     = !rst_i && pre_req && scrub_ack_i;
        s0 = rd_valid_i[0] && single_error_flag_i[0] && !double_error_flag_i[0];
        s1 = rd_valid_i[1] && single_error_flag_i[1] && !double_error_flag_i[1];
        d0 = rd_valid_i[0] && double_error_flag_i[0];
        d1 = rd_valid_i[1] && double_error_flag_i[1];
        @(posedge clk_i);
        if (rst_i) begin
            m_sec = 0; m_ded = 0; m_dv = 0; m_dch = 0; m_daddr = 0; m_drop = 0;
            mq.delete();
        end else begin
            if (pop) begin
                obs_q.push_back({1'b1, pre_e});
                if (mq.size() > 0) exp_q.push_back({1'b1, mq.pop_front()});
                else exp_q.push_back('0);
            end
            space = DEPTH - mq.size();
            drop_evt = 0;
            if (cfg_scrub_enable_i) begin
                if (s0) begin
                    if (space > 0) begin mq.push_back({1'b0, rd_addr0_i, corr_data0_i}); space--; end
                    else drop_evt = 1;
                end
                if (s1) begin
                    if (space > 0) begin mq.push_back({1'b1, rd_addr1_i, corr_data1_i}); space--; end
                    else drop_evt = 1;
                end
            end
            if (err_clr_i) begin
                m_sec = 0; m_ded = 0; m_dv = 0; m_dch = 0; m_daddr = 0; m_drop = 0;
            end else begin
                m_sec = m_sec + int'(s0) + int'(s1);
                if (m_sec > MAXC) m_sec = MAXC;
                m_ded = m_ded + int'(d0) + int'(d1);
                if (m_ded > MAXC) m_ded = MAXC;
                if (!m_dv && (d0 || d1)) begin
                    m_dv = 1; m_dch = !d0; m_daddr = d0 ? int'(rd_addr0_i) : int'(rd_addr1_i);
                end
                if (drop_evt) m_drop = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic sec(input int ch, input int addr, input logic [31:0] data);
        rd_valid_i[ch] = 1'b1; single_error_flag_i[ch] = 1'b1; double_error_flag_i[ch] = 1'b0;
        if (ch == 0) begin rd_addr0_i = ADDR_W'(addr); corr_data0_i = data; end
        else begin rd_addr1_i = ADDR_W'(addr); corr_data1_i = data; end
    endtask

    task automatic test_reset();
        cfg_scrub_enable_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sec(i % 2, $urandom_range(0, 1023), $urandom);
            double_error_flag_i[1] = (i == 3);
            cycle();
        end
        do_reset();
        checks++; if (scrub_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", scrub_req_o); end
        checks++; if ({scrub_ch_o, scrub_addr_o, scrub_data_o} !== 43'd0) begin errors++;
            $display("FAIL reset_payload got=%0h exp=0", {scrub_ch_o, scrub_addr_o, scrub_data_o}); end
        checks++; if ({sec_cnt_o, ded_cnt_o} !== 32'd0) begin errors++;
            $display("FAIL reset_counts sec=%0d ded=%0d exp=0", sec_cnt_o, ded_cnt_o); end
        checks++; if ({ded_valid_o, ded_ch_o, ded_addr_o, scrub_drop_o} !== 13'd0) begin errors++;
            $display("FAIL reset_capture got=%0h exp=0", {ded_valid_o, ded_ch_o, ded_addr_o, scrub_drop_o}); end
        repeat (3) cycle();
        checks++; if (scrub_req_o !== 1'b0) begin errors++; $display("FAIL reset_queue_empty req=%0b exp=0", scrub_req_o); end
    endtask

    task automatic test_sec_latency();
        int mark;
        do_reset();
        mark = obs_q.size();
        cfg_scrub_enable_i = 1'b1;
        sec(0, 'h155, 32'hDEADBEEF);
        cycle();
        set_idle();
        checks++; if (scrub_req_o !== 1'b0) begin errors++; $display("FAIL lat_early req=%0b exp=0", scrub_req_o); end
        cycle();
        checks++; if (scrub_req_o !== 1'b1) begin errors++; $display("FAIL lat_req req=%0b exp=1", scrub_req_o); end
        checks++; if ({scrub_ch_o, scrub_addr_o, scrub_data_o} !== {1'b0, 10'h155, 32'hDEADBEEF}) begin errors++;
            $display("FAIL lat_payload got=%0h exp=%0h", {scrub_ch_o, scrub_addr_o, scrub_data_o}, {1'b0, 10'h155, 32'hDEADBEEF}); end
        checks++; if (sec_cnt_o !== 16'd1) begin errors++; $display("FAIL lat_sec_cnt got=%0d exp=1", sec_cnt_o); end
        scrub_ack_i = 1'b1; cycle(); scrub_ack_i = 1'b0;
        checks++; if (scrub_req_o !== 1'b0) begin errors++; $display("FAIL lat_after_ack req=%0b exp=0", scrub_req_o); end
        repeat (3) cycle();
        checks++; if (scrub_req_o !== 1'b0) begin errors++; $display("FAIL lat_idle req=%0b exp=0", scrub_req_o); end
        checks++; if (obs_q.size() - mark != 1) begin errors++; $display("FAIL lat_pops got=%0d exp=1", obs_q.size() - mark); end
    endtask

    task automatic test_dual_sec();
        int mark; int a0, a1; logic [31:0] d0, d1;
        do_reset();
        mark = obs_q.size();
        a0 = $urandom_range(0, 1023); a1 = $urandom_range(0, 1023); d0 = $urandom; d1 = $urandom;
        cfg_scrub_enable_i = 1'b1;
        sec(0, a0, d0); sec(1, a1, d1);
        cycle(); set_idle(); cycle();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({scrub_req_o, scrub_ch_o, scrub_addr_o, scrub_data_o} !== {1'b1, 1'b0, ADDR_W'(a0), d0}) begin errors++;
                $display("FAIL dual_first_hold[%0d] got=%0h exp=%0h", i, {scrub_req_o, scrub_ch_o, scrub_addr_o, scrub_data_o},
                         {1'b1, 1'b0, ADDR_W'(a0), d0}); end
            cycle();
        end
        scrub_ack_i = 1'b1; cycle(); scrub_ack_i = 1'b0;
        checks++; if (scrub_req_o !== 1'b0) begin errors++; $display("FAIL dual_gap req=%0b exp=0", scrub_req_o); end
        cycle();
        checks++; if ({scrub_req_o, scrub_ch_o, scrub_addr_o, scrub_data_o} !== {1'b1, 1'b1, ADDR_W'(a1), d1}) begin errors++;
            $display("FAIL dual_second got=%0h exp=%0h", {scrub_req_o, scrub_ch_o, scrub_addr_o, scrub_data_o}, {1'b1, 1'b1, ADDR_W'(a1), d1}); end
        checks++; if (sec_cnt_o !== 16'd2) begin errors++; $display("FAIL dual_sec_cnt got=%0d exp=2", sec_cnt_o); end
        scrub_ack_i = 1'b1; cycle(); scrub_ack_i = 1'b0;
        repeat (3) cycle();
        checks++; if (obs_q.size() - mark != 2) begin errors++; $display("FAIL dual_pops got=%0d exp=2", obs_q.size() - mark); end
    endtask

    task automatic test_ded();
        int reqs = 0;
        do_reset();
        cfg_scrub_enable_i = 1'b1;
        rd_valid_i = 2'b10; double_error_flag_i = 2'b10; single_error_flag_i = 2'b10; rd_addr1_i = 10'h3FF;
        cycle(); set_idle();
        rd_valid_i = 2'b01; double_error_flag_i = 2'b01; rd_addr0_i = 10'h001;
        cycle(); set_idle();
        rd_valid_i = 2'b00; double_error_flag_i = 2'b11; single_error_flag_i = 2'b11;
        cycle(); set_idle();
        for (int i = 0; i < 5; i++) begin if (scrub_req_o) reqs++; cycle(); end
        checks++; if ({ded_valid_o, ded_ch_o, ded_addr_o} !== {1'b1, 1'b1, 10'h3FF}) begin errors++;
            $display("FAIL ded_capture got=%0h exp=%0h", {ded_valid_o, ded_ch_o, ded_addr_o}, {1'b1, 1'b1, 10'h3FF}); end
        checks++; if (ded_cnt_o !== 16'd2) begin errors++; $display("FAIL ded_cnt got=%0d exp=2", ded_cnt_o); end
        checks++; if (sec_cnt_o !== 16'd0) begin errors++; $display("FAIL ded_sec_cnt got=%0d exp=0", sec_cnt_o); end
        checks++; if (reqs != 0) begin errors++; $display("FAIL ded_no_req got=%0d exp=0", reqs); end
    endtask

    task automatic test_overflow();
        int mark;
        do_reset();
        mark = obs_q.size();
        cfg_scrub_enable_i = 1'b1;
        for (int i = 0; i < 6; i++) begin sec(0, $urandom_range(0, 1023), $urandom); cycle(); end
        set_idle(); cycle();
        checks++; if (scrub_drop_o !== 1'b1) begin errors++; $display("FAIL ovf_drop got=%0b exp=1", scrub_drop_o); end
        checks++; if (sec_cnt_o !== 16'd6) begin errors++; $display("FAIL ovf_sec_cnt got=%0d exp=6", sec_cnt_o); end
        scrub_ack_i = 1'b1; repeat (16) cycle(); scrub_ack_i = 1'b0; cycle();
        checks++; if (obs_q.size() - mark != 4) begin errors++; $display("FAIL ovf_pops got=%0d exp=4", obs_q.size() - mark); end
        for (int i = mark; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_entry[%0d] got=%0h exp=%0h", i - mark, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_push_pop();
        int mark;
        do_reset();
        mark = obs_q.size();
        cfg_scrub_enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin sec(0, $urandom_range(0, 1023), $urandom); cycle(); end
        set_idle(); cycle();
        sec(0, $urandom_range(0, 1023), $urandom); scrub_ack_i = 1'b1;
        cycle(); set_idle();
        checks++; if (scrub_drop_o !== 1'b0) begin errors++; $display("FAIL full_pushpop_drop got=%0b exp=0", scrub_drop_o); end
        scrub_ack_i = 1'b1; repeat (16) cycle(); scrub_ack_i = 1'b0; cycle();
        checks++; if (obs_q.size() - mark != 5) begin errors++; $display("FAIL full_pushpop_pops got=%0d exp=5", obs_q.size() - mark); end
        for (int i = mark; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_entry[%0d] got=%0h exp=%0h", i - mark, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_enable_mid_req();
        int mark;
        do_reset();
        mark = obs_q.size();
        cfg_scrub_enable_i = 1'b1;
        sec(0, 5, 32'h1111_0000); sec(1, 6, 32'h2222_0000); cycle(); set_idle(); cycle();
        cfg_scrub_enable_i = 1'b0;
        sec(1, 7, 32'h3333_0000); cycle(); set_idle();
        repeat (2) cycle();
        checks++; if (scrub_req_o !== 1'b1) begin errors++; $display("FAIL en_hold_req got=%0b exp=1", scrub_req_o); end
        scrub_ack_i = 1'b1; repeat (10) cycle(); scrub_ack_i = 1'b0; cycle();
        checks++; if (obs_q.size() - mark != 2) begin errors++; $display("FAIL en_pops got=%0d exp=2", obs_q.size() - mark); end
        checks++; if (sec_cnt_o !== 16'd3) begin errors++; $display("FAIL en_sec_cnt got=%0d exp=3", sec_cnt_o); end
    endtask

    task automatic test_saturate();
        do_reset();
        cfg_scrub_enable_i = 1'b0;
        rd_valid_i = 2'b10; double_error_flag_i = 2'b10; rd_addr1_i = 10'h2A;
        cycle();
        rd_valid_i = 2'b11; single_error_flag_i = 2'b11; double_error_flag_i = 2'b00;
        repeat (32767) cycle();
        rd_valid_i = 2'b01;
        cycle();
        checks++; if (sec_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%0h exp=ffff", sec_cnt_o); end
        rd_valid_i = 2'b11;
        repeat (3) cycle();
        checks++; if (sec_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0h exp=ffff", sec_cnt_o); end
        err_clr_i = 1'b1; cycle(); set_idle();
        checks++; if (sec_cnt_o !== 16'd0) begin errors++; $display("FAIL clr_sec got=%0d exp=0", sec_cnt_o); end
        checks++; if ({ded_valid_o, ded_cnt_o} !== 17'd0) begin errors++;
            $display("FAIL clr_ded got=%0h exp=0", {ded_valid_o, ded_cnt_o}); end
    endtask

    task automatic test_reset_mid_req();
        int reqs = 0;
        do_reset();
        cfg_scrub_enable_i = 1'b1;
        for (int i = 0; i < 3; i++) begin sec(1, $urandom_range(0, 1023), $urandom); cycle(); end
        set_idle();
        for (int i = 0; i < 10 && !scrub_req_o; i++) cycle();
        checks++; if (scrub_req_o !== 1'b1) begin errors++; $display("FAIL rstreq_setup got=%0b exp=1", scrub_req_o); end
        rst_i = 1'b1; cycle(); rst_i = 1'b0;
        checks++; if (scrub_req_o !== 1'b0) begin errors++; $display("FAIL rstreq_drop got=%0b exp=0", scrub_req_o); end
        for (int i = 0; i < 10; i++) begin cycle(); if (scrub_req_o) reqs++; end
        checks++; if (reqs != 0) begin errors++; $display("FAIL rstreq_no_more got=%0d exp=0", reqs); end
    endtask

    task automatic test_random();
        int mark; bit prev_req, prev_ack; logic [42:0] prev_e;
        do_reset();
        mark = obs_q.size();
        for (int n = 0; n < 3000; n++) begin
            cfg_scrub_enable_i  = ($urandom_range(0, 7) != 0);
            rd_valid_i          = 2'($urandom);
            single_error_flag_i = 2'($urandom);
            double_error_flag_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            rd_addr0_i   = ADDR_W'($urandom); rd_addr1_i   = ADDR_W'($urandom);
            corr_data0_i = $urandom;          corr_data1_i = $urandom;
            err_clr_i    = ($urandom_range(0, 63) == 0);
            scrub_ack_i  = ($urandom_range(0, 2) == 0);
            prev_req = scrub_req_o; prev_ack = scrub_ack_i;
            prev_e   = {scrub_ch_o, scrub_addr_o, scrub_data_o};
            cycle();
            checks++; if ({sec_cnt_o, ded_cnt_o} !== {CNT_W'(m_sec), CNT_W'(m_ded)}) begin errors++;
                $display("FAIL rnd_counts[%0d] sec=%0d ded=%0d exp sec=%0d ded=%0d", n, sec_cnt_o, ded_cnt_o, m_sec, m_ded); end
            checks++; if ({ded_valid_o, ded_ch_o, ded_addr_o, scrub_drop_o} !== {m_dv, m_dch, ADDR_W'(m_daddr), m_drop}) begin errors++;
                $display("FAIL rnd_status[%0d] got=%0h exp=%0h", n, {ded_valid_o, ded_ch_o, ded_addr_o, scrub_drop_o},
                         {m_dv, m_dch, ADDR_W'(m_daddr), m_drop}); end
            if (prev_req && !prev_ack && scrub_req_o) begin
                checks++; if ({scrub_ch_o, scrub_addr_o, scrub_data_o} !== prev_e) begin errors++;
                    $display("FAIL rnd_stable[%0d] got=%0h exp=%0h", n, {scrub_ch_o, scrub_addr_o, scrub_data_o}, prev_e); end
            end
        end
        set_idle(); cfg_scrub_enable_i = 1'b0; scrub_ack_i = 1'b1;
        repeat (16) cycle();
        scrub_ack_i = 1'b0; cycle();
        checks++; if (mq.size() != 0) begin errors++; $display("FAIL rnd_drain left=%0d exp=0", mq.size()); end
        for (int i = mark; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_entry[%0d] got=%0h exp=%0h", i - mark, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_sec_latency();
        test_dual_sec();
        test_ded();
        test_overflow();
        test_full_push_pop();
        test_enable_mid_req();
        test_reset_mid_req();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM word address width (1K x 40-bit non-split).
REQ-002 Parameter CNT_W, default 16, error counter width.
REQ-003 Parameter DEPTH, default 4, scrub queue entries (power of two, >=2).
REQ-004 clk_i  in  1  single block clock; all logic rising-edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 cfg_scrub_enable_i  in  1  enables scrub write-back requests; counters run regardless.
REQ-007 rd_valid_i  in  2  per ECC decoder channel: read data and flags valid this cycle.
REQ-008 rd_addr0_i / rd_addr1_i  in  ADDR_W each  word address of channel 0/1 read.
REQ-009 single_error_flag_i / double_error_flag_i  in  2 each  decoder flags, bit n = channel n.
REQ-010 corr_data0_i / corr_data1_i  in  32 each  corrected decoder data per channel.
REQ-011 err_clr_i  in  1  clears counters and sticky status.
REQ-012 scrub_req_o  out  1  write-back request; scrub_ack_i  in  1  write-back accepted.
REQ-013 scrub_ch_o out 1, scrub_addr_o out ADDR_W, scrub_data_o out 32: write-back target and payload.
REQ-014 sec_cnt_o / ded_cnt_o  out  CNT_W each  corrected / uncorrectable error counts.
REQ-015 ded_valid_o out 1, ded_ch_o out 1, ded_addr_o out ADDR_W: first uncorrectable error capture.
REQ-016 scrub_drop_o  out  1  sticky: a scrub entry was discarded.

Function
REQ-017 Channel n event qualifies only when rd_valid_i[n]=1; flags with rd_valid_i[n]=0 are ignored.
REQ-018 Qualified channel with double flag set is a DED event (single flag ignored); single flag only is a SEC event.
REQ-019 sec_cnt_o/ded_cnt_o increment by number of qualified SEC/DED events that cycle (0..2), saturating at all-ones, updated next edge.
REQ-020 First DED after reset/clear captures channel and address into ded_ch_o/ded_addr_o, sets ded_valid_o; later DEDs do not overwrite; both channels DED same cycle -> channel 0 captured.
REQ-021 SEC event with cfg_scrub_enable_i=1 pushes {ch, addr, corr_data} into FIFO queue; DED events never push.
REQ-022 Same-cycle SEC on both channels pushes channel 0 then channel 1; entries not fitting are discarded (channel 1 first) and scrub_drop_o sets.
REQ-023 FSM states IDLE, REQ, GAP: IDLE->REQ when queue non-empty; REQ->GAP on scrub_ack_i (entry popped same edge); GAP->REQ if non-empty else IDLE after one cycle.
REQ-024 scrub_req_o=1 exactly in REQ; scrub_ch_o/addr/data show queue head and hold stable while scrub_req_o=1.
REQ-025 Minimum latency: SEC at cycle N, empty queue, IDLE -> scrub_req_o=1 at cycle N+2 (push edge N, IDLE->REQ edge N+1).
REQ-026 Push and pop in same cycle on full queue: pop frees slot first, push accepted, no drop.
REQ-027 cfg_scrub_enable_i deassert mid-request does not cancel REQ; queued entries drain; new SEC not pushed.
REQ-028 err_clr_i clears counters, ded_valid_o, ded_ch_o, ded_addr_o, scrub_drop_o next edge; same-cycle events are not counted/captured; queue and FSM unaffected.

Reset
REQ-029 rst_i=1 at edge: FSM IDLE, queue empty, scrub_req_o=0, all counters, capture fields, ded_valid_o, scrub_drop_o = 0; scrub_ch/addr/data = 0.
REQ-030 Reset mid-REQ abandons the request and discards all queued entries; no ack required.

Structure
REQ-031 Package ecc_scrub_pkg holds FSM state encoding, scrub entry record (ch, addr, data) and width constants.
REQ-032 Queue is sub-module ecc_scrub_fifo (synchronous, DEPTH entries, dual push port ordered, single pop, full/empty/count).
REQ-033 No combinational path from any input to scrub_req_o; counters and capture registered.

Verification
REQ-034 SEC on ch0, addr 0x155, data 0xDEADBEEF at cycle 10 -> scrub_req_o=1 at cycle 12 with those values, sec_cnt_o=1.
REQ-035 SEC both channels same cycle, ack held 0 -> requests ch0 then ch1 in order, sec_cnt_o=2, one GAP cycle between.
REQ-036 DED ch1 addr 0x3FF then DED ch0 addr 0x001 -> ded_valid_o=1, ded_ch_o=1, ded_addr_o=0x3FF, ded_cnt_o=2, no scrub_req_o.
REQ-037 6 SECs with ack held 0, DEPTH=4 -> 4 entries queued, scrub_drop_o=1, sec_cnt_o=6.
REQ-038 sec_cnt_o preloaded to 0xFFFF via SEC stream -> further SEC leaves 0xFFFF; err_clr_i -> 0 next cycle.
REQ-039 rst_i asserted during REQ with 3 queued -> scrub_req_o=0 next cycle, no further requests after release.
